// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the interrupt controller register file.
package irq_ctrl_pkg;

  localparam int NUM_SRC_MAX = 31;

  localparam logic [4:0] IRQ_PENDING   = 5'h00;
  localparam logic [4:0] IRQ_ENABLE    = 5'h04;
  localparam logic [4:0] IRQ_MODE      = 5'h08;
  localparam logic [4:0] IRQ_CLAIM     = 5'h0C;
  localparam logic [4:0] IRQ_INSERVICE = 5'h10;

  localparam logic [4:0] CLAIM_NONE = 5'd0;

  // Returns index+1 of the lowest set bit, CLAIM_NONE when the vector is empty.
  function automatic logic [4:0] lowest_id1(input logic [NUM_SRC_MAX-1:0] v);
    logic [4:0] id;
    id = CLAIM_NONE;
    for (int i = NUM_SRC_MAX - 1; i >= 0; i--) begin
      if (v[i]) id = 5'(i + 1);
    end
    return id;
  endfunction

endpackage

// File: rtl/wishbone_interface.sv
// Classic 32-bit Wishbone bus bundle.
interface wishbone_interface;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wr_dat;
  logic [31:0] rd_dat;
  logic [3:0]  sel;
  logic        ack;

  modport master (output cyc, stb, we, adr, wr_dat, sel, input rd_dat, ack);
  modport slave  (input cyc, stb, we, adr, wr_dat, sel, output rd_dat, ack);
endinterface

// File: rtl/irq_sync.sv
// Purpose: synchronise one async interrupt line, emit registered level and rise pulse.
// Latency: input sampled at edge k shows on level/rise after edge k+SYNC_STAGES.
// Backpressure: none; free-running every cycle.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   rise_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      level_q <= sync_q[SYNC_STAGES-1];
      // level_q doubles as the previous-value flop for edge detection
      rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/irq_controller.sv
// Purpose: prioritised interrupt controller with claim/complete Wishbone register file.
// Latency: source high before edge k raises irq_out after edge k+SYNC_STAGES+2; bus ack 1 cycle after request.
// Backpressure: single outstanding access, ack pulses one cycle, held stb acks every second cycle.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  wishbone_interface.slave   bus,
  input  logic [NUM_SRC-1:0] irq_src_in,
  output logic               irq_out
);

  logic [NUM_SRC-1:0] level, rise;
  logic [NUM_SRC-1:0] pending, enable, mode, in_service;
  logic [NUM_SRC-1:0] pending_n, enable_n, mode_n, in_service_n;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC_MAX-1:0] elig_ext;
  logic [4:0]  off, claim_id;
  logic        access, wr, rd, claim_fire;
  logic        ack_q;
  logic [31:0] rd_dat_q, rd_dat_n;
  logic [31:0] pend_w, en_w, mode_w, insvc_w;
  logic        unused_bits;

  assign unused_bits = ^{bus.sel, bus.adr[31:5], bus.adr[1:0]};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (irq_src_in[g]),
      .level    (level[g]),
      .rise     (rise[g])
    );
  end

  always_comb begin
    access   = bus.cyc & bus.stb & ~ack_q;
    wr       = access & bus.we;
    rd       = access & ~bus.we;
    off      = {bus.adr[4:2], 2'b00};
    eligible = pending & enable & ~in_service;
    elig_ext = '0;
    elig_ext[NUM_SRC-1:0] = eligible;
    claim_id   = lowest_id1(elig_ext);
    claim_fire = rd && (off == IRQ_CLAIM) && (claim_id != CLAIM_NONE);

    pend_w  = '0;
    en_w    = '0;
    mode_w  = '0;
    insvc_w = '0;
    pend_w[NUM_SRC-1:0]  = pending;
    en_w[NUM_SRC-1:0]    = enable;
    mode_w[NUM_SRC-1:0]  = mode;
    insvc_w[NUM_SRC-1:0] = in_service;

    case (off)
      IRQ_PENDING:   rd_dat_n = pend_w;
      IRQ_ENABLE:    rd_dat_n = en_w;
      IRQ_MODE:      rd_dat_n = mode_w;
      IRQ_CLAIM:     rd_dat_n = {27'd0, claim_id};
      IRQ_INSERVICE: rd_dat_n = insvc_w;
      default:       rd_dat_n = '0;
    endcase
  end

  always_comb begin
    enable_n     = enable;
    mode_n       = mode;
    pending_n    = pending;
    in_service_n = in_service;
    if (wr && off == IRQ_ENABLE) enable_n = bus.wr_dat[NUM_SRC-1:0];
    if (wr && off == IRQ_MODE)   mode_n   = bus.wr_dat[NUM_SRC-1:0];

    for (int i = 0; i < NUM_SRC; i++) begin
      // A fresh rise outranks any clear landing on the same edge
      if (!mode[i]) begin
        pending_n[i] = level[i];
      end else begin
        pending_n[i] = rise[i] |
                       (pending[i] & ~((wr && off == IRQ_PENDING && bus.wr_dat[i]) ||
                                       (claim_fire && claim_id == 5'(i + 1))));
      end
      if (claim_fire && claim_id == 5'(i + 1)) begin
        in_service_n[i] = 1'b1;
      end else if (wr && off == IRQ_CLAIM && bus.wr_dat == 32'(i + 1)) begin
        in_service_n[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending    <= '0;
      enable     <= '0;
      mode       <= '0;
      in_service <= '0;
      ack_q      <= 1'b0;
      rd_dat_q   <= '0;
      irq_out    <= 1'b0;
    end else begin
      pending    <= pending_n;
      enable     <= enable_n;
      mode       <= mode_n;
      in_service <= in_service_n;
      ack_q      <= access;
      if (access) rd_dat_q <= rd_dat_n;
      irq_out    <= |eligible;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.rd_dat = rd_dat_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register table plus hand-timed corner sequences.
module tb_irq_controller;
  import irq_ctrl_pkg::*;

  localparam int NSRC = 8;
  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NSRC-1:0] irq_src_in = '0;
  logic            irq_out;
  int              errors = 0;
  int              checks = 0;

  wishbone_interface bus ();

  irq_controller #(.NUM_SRC(NSRC), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .irq_src_in (irq_src_in),
    .irq_out    (irq_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wb_access(input logic we, input logic [31:0] addr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = addr; bus.wr_dat = wdat; bus.sel = 4'hF;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.ack && n < 10);
    if (!bus.ack) begin
      errors++;
      checks++;
      $display("FAIL wb_timeout: no ack at address %0h", addr);
    end
    rdat = bus.rd_dat;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    logic [31:0] d;
    wb_access(1'b1, 32'(addr), data, d);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    wb_access(1'b0, 32'(addr), 32'd0, d);
    check(name, d, exp);
  endtask

  initial begin
    int n;
    logic [31:0] d;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.wr_dat = '0; bus.sel = '0;

    vecs[0]  = '{we: 1'b0, adr: 32'(IRQ_PENDING),   wdat: 32'h0,        exp: 32'h0};
    vecs[1]  = '{we: 1'b0, adr: 32'(IRQ_ENABLE),    wdat: 32'h0,        exp: 32'h0};
    vecs[2]  = '{we: 1'b0, adr: 32'(IRQ_MODE),      wdat: 32'h0,        exp: 32'h0};
    vecs[3]  = '{we: 1'b0, adr: 32'(IRQ_CLAIM),     wdat: 32'h0,        exp: 32'h0};
    vecs[4]  = '{we: 1'b0, adr: 32'(IRQ_INSERVICE), wdat: 32'h0,        exp: 32'h0};
    vecs[5]  = '{we: 1'b1, adr: 32'(IRQ_ENABLE),    wdat: 32'hFFFFFF5A, exp: 32'h0};
    vecs[6]  = '{we: 1'b0, adr: 32'(IRQ_ENABLE),    wdat: 32'h0,        exp: 32'h5A};
    vecs[7]  = '{we: 1'b1, adr: 32'(IRQ_MODE),      wdat: 32'h3C,       exp: 32'h0};
    vecs[8]  = '{we: 1'b0, adr: 32'(IRQ_MODE),      wdat: 32'h0,        exp: 32'h3C};
    vecs[9]  = '{we: 1'b1, adr: 32'(IRQ_INSERVICE), wdat: 32'hFF,       exp: 32'h0};
    vecs[10] = '{we: 1'b0, adr: 32'(IRQ_INSERVICE), wdat: 32'h0,        exp: 32'h0};
    vecs[11] = '{we: 1'b0, adr: 32'h1C,             wdat: 32'h0,        exp: 32'h0};
    vecs[12] = '{we: 1'b1, adr: 32'h14,             wdat: 32'hFFFFFFFF, exp: 32'h0};
    vecs[13] = '{we: 1'b0, adr: 32'(IRQ_ENABLE),    wdat: 32'h0,        exp: 32'h5A};
    vecs[14] = '{we: 1'b0, adr: 32'h18,             wdat: 32'h0,        exp: 32'h0};
    vecs[15] = '{we: 1'b1, adr: 32'(IRQ_ENABLE),    wdat: 32'h0,        exp: 32'h0};
    vecs[16] = '{we: 1'b1, adr: 32'(IRQ_MODE),      wdat: 32'h0,        exp: 32'h0};

    // Reset with all lines asserted, release with lines low
    irq_src_in = '1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    irq_src_in = '0;
    check("reset_irq_out", 32'(irq_out), 32'h0);
    check("reset_ack", 32'(bus.ack), 32'h0);

    for (int i = 0; i < 17; i++) begin
      wb_access(vecs[i].we, vecs[i].adr, vecs[i].wdat, d);
      if (!vecs[i].we) check($sformatf("vec%0d", i), d, vecs[i].exp);
    end

    // Edge latency on src0
    wr(IRQ_MODE, 32'hFF);
    wr(IRQ_ENABLE, 32'h01);
    irq_src_in[0] = 1'b1;
    @(posedge clk); #1;
    irq_src_in[0] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!irq_out && n < 20);
    check("edge_latency", 32'(n), 32'(SYNC + 2));
    rd_chk("edge_claim", IRQ_CLAIM, 32'd1);
    rd_chk("edge_pending", IRQ_PENDING, 32'h0);
    rd_chk("edge_insvc", IRQ_INSERVICE, 32'h01);
    check("edge_irq_drop", 32'(irq_out), 32'h0);
    wr(IRQ_CLAIM, 32'd1);
    rd_chk("edge_complete", IRQ_INSERVICE, 32'h0);

    // Priority in level mode
    wr(IRQ_MODE, 32'h00);
    wr(IRQ_ENABLE, 32'hFF);
    irq_src_in[5] = 1'b1;
    irq_src_in[2] = 1'b1;
    repeat (6) @(posedge clk);
    rd_chk("prio_claim_a", IRQ_CLAIM, 32'd3);
    rd_chk("prio_claim_b", IRQ_CLAIM, 32'd6);
    rd_chk("prio_claim_c", IRQ_CLAIM, 32'd0);
    rd_chk("prio_insvc", IRQ_INSERVICE, 32'h24);
    wr(IRQ_CLAIM, 32'd0);
    wr(IRQ_CLAIM, 32'd40);
    rd_chk("bad_complete", IRQ_INSERVICE, 32'h24);
    wr(IRQ_CLAIM, 32'd3);
    rd_chk("prio_reclaim", IRQ_CLAIM, 32'd3);
    wr(IRQ_CLAIM, 32'd3);
    wr(IRQ_CLAIM, 32'd6);
    rd_chk("prio_all_done", IRQ_INSERVICE, 32'h0);
    irq_src_in = '0;
    repeat (6) @(posedge clk);

    // W1C colliding with a new rise on src1
    wr(IRQ_ENABLE, 32'h0);
    wr(IRQ_MODE, 32'h02);
    irq_src_in[1] = 1'b1;
    @(posedge clk); #1;
    irq_src_in[1] = 1'b0;
    repeat (6) @(posedge clk);
    rd_chk("w1c_pre", IRQ_PENDING, 32'h02);
    irq_src_in[1] = 1'b1;
    @(posedge clk); #1;
    irq_src_in[1] = 1'b0;
    repeat (SYNC) @(posedge clk);
    #1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'(IRQ_PENDING); bus.wr_dat = 32'h02;
    @(posedge clk); #1;
    check("w1c_ack", 32'(bus.ack), 32'h1);
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    rd_chk("w1c_collision", IRQ_PENDING, 32'h02);
    wr(IRQ_PENDING, 32'h02);
    rd_chk("w1c_clear", IRQ_PENDING, 32'h0);

    // Masking
    wr(IRQ_MODE, 32'h0);
    irq_src_in[3] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("mask_irq_low", 32'(irq_out), 32'h0);
    rd_chk("mask_claim", IRQ_CLAIM, 32'd0);
    wr(IRQ_ENABLE, 32'h08);
    check("mask_irq_at_ack", 32'(irq_out), 32'h0);
    @(posedge clk); #1;
    check("mask_irq_rise", 32'(irq_out), 32'h1);
    wr(IRQ_ENABLE, 32'h00);
    check("unmask_irq_at_ack", 32'(irq_out), 32'h1);
    @(posedge clk); #1;
    check("unmask_irq_drop", 32'(irq_out), 32'h0);
    irq_src_in[3] = 1'b0;

    // Held strobe acks on alternating cycles
    @(posedge clk); #1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'(IRQ_ENABLE);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("held_ack%0d", i), 32'(bus.ack), (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    bus.cyc = 1'b0; bus.stb = 1'b0;

    // Reset arriving with an access: no ack, no write
    @(posedge clk); #1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'(IRQ_ENABLE); bus.wr_dat = 32'hFF;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ack", 32'(bus.ack), 32'h0);
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    rst = 1'b1;
    rd_chk("rst_mid_enable", IRQ_ENABLE, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised interrupt controller between peripheral interrupt lines and the cpu's `external_interrupt_in`. It generalises the single external interrupt line into `NUM_SRC` independently synchronised sources, each with a per-source level/edge mode, an enable bit, and fixed priority. Software interacts through a Wishbone slave register file using a claim/complete protocol. The block sits on the data-side Wishbone bus next to the timer; its `irq_out` drives the cpu.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources, legal range 1..31.
- `SYNC_STAGES`, default 2: synchroniser flops per source, legal range ≥ 2.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `bus` `wishbone_interface.slave`: classic Wishbone slave, 32-bit data. Uses cyc, stb, we, adr, write data, read data and ack. `sel` is ignored; accesses are whole-word.
- `irq_src_in` in `NUM_SRC`: asynchronous interrupt request lines.
- `irq_out` out 1: registered interrupt request to the cpu.

## Operation
- Registers are decoded on `adr[4:2]`; bits above `NUM_SRC` read 0.
  - 0x00 PENDING: read-only, except write-1-to-clear on edge-mode bits. Writes to level-mode bits are ignored.
  - 0x04 ENABLE: read/write mask.
  - 0x08 MODE: read/write; 1 = rising-edge, 0 = level-high.
  - 0x0C CLAIM: read returns id+1 of the lowest-numbered source with `pending & enable & ~in_service`, or 0 if none.
    - A non-zero claim sets that source's in-service bit and clears its pending bit if the source is edge-mode.
    - A write of value v (1..`NUM_SRC`) clears in-service bit v−1 ("complete"). Other values are ignored.
  - 0x10 INSERVICE: read-only mask.
  - Unmapped offsets: read 0, writes ignored, still acknowledged.
- Level mode: pending equals the synchronised line, registered once. Edge mode: pending is latched on synced 0→1 and held until claim or W1C.
- Lowest index has highest priority.
- A source that is in service is excluded from both `irq_out` and the claim result.
- `irq_out` is registered each cycle from `|(pending & enable & ~in_service)`.
- Mode change from edge to level: the pending bit follows the level from the next cycle. Mode change from level to edge: pending keeps its current value.

## Timing
- Reset: all sync/prev flops, PENDING, ENABLE, MODE, INSERVICE, `irq_out`, ack and read data are cleared to 0.
- Reset asserted mid-access drops ack the next cycle; no partial side effects occur.
- Bus handshake: ack is asserted for exactly one cycle, on the cycle after `cyc & stb & ~ack`. Read data is valid with ack, and register side effects commit on the same edge that raises ack.
  - Minimum access time is 2 cycles; a held stb produces an ack every second cycle.
- Latency: a source going high before rising edge k gives `irq_out` = 1 after edge k+`SYNC_STAGES`+2.
  - This assumes the source is enabled, not in service, and no higher-priority work is pending.
- Clearing ENABLE or claiming the last eligible source drops `irq_out` one cycle after ack.
- Simultaneous events:
  - A new synced edge in the same cycle as a W1C or claim clear leaves pending = 1 (set wins).
  - A complete and a claim can never coincide, because each bus cycle performs one access.
- Claim read data is combinational on the state before the ack edge. The claim is atomic with the read.

## Structure
- Package `irq_ctrl_pkg` holds:
  - register offset constants: `IRQ_PENDING`, `IRQ_ENABLE`, `IRQ_MODE`, `IRQ_CLAIM`, `IRQ_INSERVICE`;
  - `CLAIM_NONE` = 0;
  - a `NUM_SRC` max constant of 31.
- Sub-module `irq_sync`: a `SYNC_STAGES`-deep synchroniser per source plus a prev flop. It outputs a synced level and a one-cycle rise pulse and is instantiated `NUM_SRC` times via generate.
- The top-level contains the bus decode, the pending/enable/mode/in-service registers, the priority encoder and the `irq_out` register.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `irq_src_in` all ones. After release, all registers read 0 and `irq_out`=0.
- Edge latency: set MODE=0xFF and ENABLE=0x01, then pulse src0 high for 1 cycle. `irq_out` must rise exactly `SYNC_STAGES`+2 cycles later. CLAIM reads 1, PENDING reads 0, INSERVICE reads 0x01, and `irq_out` drops; writing 1 to CLAIM clears INSERVICE.
- Priority: level mode with ENABLE=0xFF, and src5 and src2 held high. CLAIM reads 3, then 6, then 0. Complete 3 while src2 is still high, and the next CLAIM reads 3 again.
- W1C/set collision: edge-mode src1 pending, with W1C of 0x02 issued in the same cycle as a new synced rise on src1. PENDING must read 0x02 afterwards.
- Masking: src3 is pending with ENABLE=0, so `irq_out` stays 0 and CLAIM reads 0. Write ENABLE=0x08 and `irq_out` rises one cycle after ack.
- Bus edge cases: a read of offset 0x1C returns 0 with ack. A completion write of 0 or 40 leaves INSERVICE unchanged. A held stb acks on alternating cycles.
